// File: rtl/button_counter.sv
// Push-button front end for the BCD display path: three active-low keys are
// synchronised and debounced, and their press edges step a wrapping counter.

module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_n,
   output logic press
);
   // state         | meaning
   // RELEASED      | key idle, waiting for a low level
   // PRESS_WAIT    | low seen, counting stable low cycles
   // PRESSED       | press accepted, waiting for a high level
   // RELEASE_WAIT  | high seen, counting stable high cycles

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   logic          sync_1;
   logic          sync_2;
   state_t        state;
   logic [CW-1:0] cnt;

   // Flops reset to the released level so a held key after reset reads as new.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
      end else begin
         sync_1 <= btn_n;
         sync_2 <= sync_1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RELEASED;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         case (state)
            RELEASED: begin
               if (!sync_2) begin
                  state <= PRESS_WAIT;
                  cnt   <= CW'(1);
               end
            end
            PRESS_WAIT: begin
               if (sync_2) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state <= PRESSED;
                  cnt   <= '0;
                  press <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            PRESSED: begin
               if (sync_2) begin
                  state <= RELEASE_WAIT;
                  cnt   <= CW'(1);
               end
            end
            RELEASE_WAIT: begin
               if (!sync_2) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= RELEASED;
               cnt   <= '0;
            end
         endcase
      end
   end
endmodule

module button_counter #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int WIDTH           = 4,
   parameter int MAX_VALUE       = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_up_n,
   input  logic             btn_down_n,
   input  logic             btn_load_n,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VALUE);

   logic up_evt;
   logic down_evt;
   logic load_evt;

   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (btn_up_n),
      .press (up_evt)
   );

   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (btn_down_n),
      .press (down_evt)
   );

   button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
      .clk   (clk),
      .rst_n (rst_n),
      .btn_n (btn_load_n),
      .press (load_evt)
   );

   // Load beats up/down; opposing up and down cancel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (load_evt) begin
            count <= (load_value > MAX_V) ? MAX_V : load_value;
         end else if (up_evt && down_evt) begin
            count <= count;
         end else if (up_evt) begin
            if (count >= MAX_V) begin
               count <= '0;
               wrap  <= 1'b1;
            end else begin
               count <= count + WIDTH'(1);
            end
         end else if (down_evt) begin
            if (count == '0) begin
               count <= MAX_V;
               wrap  <= 1'b1;
            end else begin
               count <= count - WIDTH'(1);
            end
         end
      end
   end
endmodule

// File: tb/tb_button_counter.sv
// Directed bench for button_counter with a 4-cycle debounce window; a second
// instance with MAX_VALUE=9 shares the stimulus to cover load clamping.

module tb_button_counter;
   logic       clk = 1'b0;
   logic       clk_en = 1'b1;
   logic       rst_n;
   logic       btn_up_n, btn_down_n, btn_load_n;
   logic [3:0] load_value;
   logic [3:0] count, count9;
   logic       wrap, wrap9;

   int pass_cnt = 0;
   int total = 0;
   int wrap_cnt = 0;
   int wrap9_cnt = 0;
   int w0;

   button_counter #(.DEBOUNCE_CYCLES(4), .WIDTH(4), .MAX_VALUE(15)) dut (
      .clk(clk), .rst_n(rst_n), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
      .btn_load_n(btn_load_n), .load_value(load_value), .count(count), .wrap(wrap)
   );

   button_counter #(.DEBOUNCE_CYCLES(4), .WIDTH(4), .MAX_VALUE(9)) dut9 (
      .clk(clk), .rst_n(rst_n), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
      .btn_load_n(btn_load_n), .load_value(load_value), .count(count9), .wrap(wrap9)
   );

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   always @(negedge clk) begin
      if (wrap === 1'b1) wrap_cnt++;
      if (wrap9 === 1'b1) wrap9_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; btn_up_n = 1'b1; btn_down_n = 1'b1; btn_load_n = 1'b1;
      load_value = 4'd0;
      tick(3);
      rst_n = 1'b1;
      tick(2);
      total++;
      if (count !== 4'd0) $display("FAIL reset_initial: count=%0d expected 0", count);
      else pass_cnt++;
      btn_up_n = 1'b0; tick(12); btn_up_n = 1'b1; tick(10);
      total++;
      if (count !== 4'd1) $display("FAIL reset_preload: count=%0d expected 1", count);
      else pass_cnt++;
      clk_en = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      total++;
      if (count !== 4'd0 || wrap !== 1'b0)
         $display("FAIL reset_async: count=%0d wrap=%0b expected 0/0", count, wrap);
      else pass_cnt++;
      #2 clk_en = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(20);
      total++;
      if (count !== 4'd0 || wrap !== 1'b0)
         $display("FAIL reset_idle: count=%0d wrap=%0b expected 0/0", count, wrap);
      else pass_cnt++;
   endtask

   task automatic test_clean_press;
      w0 = wrap_cnt;
      btn_up_n = 1'b0;
      tick(6);
      total++;
      if (count !== 4'd0) $display("FAIL press_edge6: count=%0d expected 0", count);
      else pass_cnt++;
      tick(1);
      total++;
      if (count !== 4'd1) $display("FAIL press_edge7: count=%0d expected 1", count);
      else pass_cnt++;
      tick(5);
      total++;
      if (count !== 4'd1) $display("FAIL press_hold: count=%0d expected 1", count);
      else pass_cnt++;
      btn_up_n = 1'b1; tick(10);
      btn_up_n = 1'b0; tick(12);
      btn_up_n = 1'b1; tick(10);
      total++;
      if (count !== 4'd2 || wrap_cnt !== w0)
         $display("FAIL press_second: count=%0d wraps=%0d expected 2/%0d", count, wrap_cnt, w0);
      else pass_cnt++;
   endtask

   task automatic test_bounce;
      for (int i = 0; i < 5; i++) begin
         btn_up_n = 1'b0; tick(2);
         btn_up_n = 1'b1; tick(1);
      end
      total++;
      if (count !== 4'd2) $display("FAIL bounce_pre: count=%0d expected 2", count);
      else pass_cnt++;
      btn_up_n = 1'b0; tick(10);
      btn_up_n = 1'b1; tick(10);
      total++;
      if (count !== 4'd3) $display("FAIL bounce_press: count=%0d expected 3", count);
      else pass_cnt++;
      btn_up_n = 1'b0; tick(3);
      btn_up_n = 1'b1; tick(10);
      total++;
      if (count !== 4'd3) $display("FAIL glitch3: count=%0d expected 3", count);
      else pass_cnt++;
      btn_up_n = 1'b0; tick(10);
      for (int i = 0; i < 3; i++) begin
         btn_up_n = 1'b1; tick(2);
         btn_up_n = 1'b0; tick(1);
      end
      btn_up_n = 1'b1; tick(10);
      total++;
      if (count !== 4'd4) $display("FAIL release_bounce: count=%0d expected 4", count);
      else pass_cnt++;
   endtask

   task automatic test_wrap;
      w0 = wrap_cnt;
      load_value = 4'd15;
      btn_load_n = 1'b0; tick(10); btn_load_n = 1'b1; tick(10);
      total++;
      if (count !== 4'd15 || wrap_cnt !== w0)
         $display("FAIL load15: count=%0d wraps=%0d expected 15/%0d", count, wrap_cnt, w0);
      else pass_cnt++;
      btn_up_n = 1'b0; tick(10); btn_up_n = 1'b1; tick(10);
      total++;
      if (count !== 4'd0 || wrap_cnt !== w0 + 1)
         $display("FAIL wrap_up: count=%0d wraps=%0d expected 0/%0d", count, wrap_cnt, w0 + 1);
      else pass_cnt++;
      btn_down_n = 1'b0; tick(10); btn_down_n = 1'b1; tick(10);
      total++;
      if (count !== 4'd15 || wrap_cnt !== w0 + 2)
         $display("FAIL wrap_down: count=%0d wraps=%0d expected 15/%0d", count, wrap_cnt, w0 + 2);
      else pass_cnt++;
      btn_down_n = 1'b0; tick(10); btn_down_n = 1'b1; tick(10);
      total++;
      if (count !== 4'd14 || wrap_cnt !== w0 + 2)
         $display("FAIL down_plain: count=%0d wraps=%0d expected 14/%0d", count, wrap_cnt, w0 + 2);
      else pass_cnt++;
   endtask

   task automatic test_simultaneous;
      w0 = wrap_cnt;
      btn_up_n = 1'b0; btn_down_n = 1'b0; tick(10);
      btn_up_n = 1'b1; btn_down_n = 1'b1; tick(10);
      total++;
      if (count !== 4'd14 || wrap_cnt !== w0)
         $display("FAIL up_down: count=%0d wraps=%0d expected 14/%0d", count, wrap_cnt, w0);
      else pass_cnt++;
      load_value = 4'd6;
      btn_load_n = 1'b0; btn_up_n = 1'b0; tick(10);
      btn_load_n = 1'b1; btn_up_n = 1'b1; tick(10);
      total++;
      if (count !== 4'd6) $display("FAIL load_up: count=%0d expected 6", count);
      else pass_cnt++;
   endtask

   task automatic test_max_clamp;
      rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(2);
      w0 = wrap9_cnt;
      load_value = 4'd12;
      btn_load_n = 1'b0; tick(10); btn_load_n = 1'b1; tick(10);
      total++;
      if (count9 !== 4'd9 || count !== 4'd12)
         $display("FAIL clamp_load: count9=%0d count=%0d expected 9/12", count9, count);
      else pass_cnt++;
      btn_up_n = 1'b0; tick(10); btn_up_n = 1'b1; tick(10);
      total++;
      if (count9 !== 4'd0 || wrap9_cnt !== w0 + 1)
         $display("FAIL clamp_wrap: count9=%0d wraps=%0d expected 0/%0d", count9, wrap9_cnt, w0 + 1);
      else pass_cnt++;
      total++;
      if (count !== 4'd13) $display("FAIL clamp_ref: count=%0d expected 13", count);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_debounce;
      btn_up_n = 1'b0;
      tick(4);
      rst_n = 1'b0;
      #1;
      total++;
      if (count !== 4'd0 || wrap !== 1'b0)
         $display("FAIL mid_reset: count=%0d wrap=%0b expected 0/0", count, wrap);
      else pass_cnt++;
      tick(3);
      rst_n = 1'b1;
      tick(6);
      total++;
      if (count !== 4'd0) $display("FAIL held_edge6: count=%0d expected 0", count);
      else pass_cnt++;
      tick(1);
      total++;
      if (count !== 4'd1) $display("FAIL held_edge7: count=%0d expected 1", count);
      else pass_cnt++;
      tick(8);
      btn_up_n = 1'b1; tick(10);
      total++;
      if (count !== 4'd1) $display("FAIL held_once: count=%0d expected 1", count);
      else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_clean_press;
      test_bounce;
      test_wrap;
      test_simultaneous;
      test_max_clamp;
      test_reset_mid_debounce;
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
